// File: rtl/fir_call_driver_if.sv
// Handshake bundle shared by the FIR call driver, its run controller, the fir
// component (call/return) and the downstream result consumer.
interface fir_call_driver_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [63:0] cfg_base;
  logic [15:0] cfg_count;
  logic        fir_start;
  logic        fir_busy;
  logic [63:0] fir_d_i;
  logic [63:0] fir_idx;
  logic        fir_done;
  logic        fir_stall;
  logic [31:0] fir_returndata;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_last;
  logic        run_active;

  modport master (
    input  cfg_valid, cfg_base, cfg_count, fir_busy, fir_done, fir_returndata, res_ready,
    output cfg_ready, fir_start, fir_d_i, fir_idx, fir_stall, res_valid, res_data, res_last,
           run_active
  );

  modport slave (
    output cfg_valid, cfg_base, cfg_count, fir_busy, fir_done, fir_returndata, res_ready,
    input  cfg_ready, fir_start, fir_d_i, fir_idx, fir_stall, res_valid, res_data, res_last,
           run_active
  );
endinterface

// File: rtl/fir_call_driver.sv
// Issues cfg_count pipelined fir calls over one d_i pointer and returns the results
// in call order through a credit-limited result FIFO.
module fir_call_driver #(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  fir_call_driver_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } entry_t;

  state_e        state_q, state_d;
  logic [63:0]   base_q, base_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   issued_q, issued_d;
  logic [15:0]   returned_q, returned_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          fir_start_q, fir_start_d;
  logic          fir_stall_q, fir_stall_d;
  logic          res_valid_q, res_valid_d;
  logic          cfg_ready_q, cfg_ready_d;
  entry_t        mem_q [DEPTH];

  logic          cfg_acc, call_acc, ret_acc, pop;
  logic [CW:0]   credit_used;
  entry_t        push_entry;

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cfg_acc    = bus.cfg_valid && cfg_ready_q;
    call_acc   = fir_start_q && !bus.fir_busy;
    ret_acc    = bus.fir_done && !fir_stall_q && (state_q != IDLE);
    pop        = res_valid_q && bus.res_ready;
    push_entry = '{last: (returned_q == count_q - 16'd1), data: bus.fir_returndata};

    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q + 16'(call_acc);
    returned_d = returned_q + 16'(ret_acc);
    occ_d      = occ_q + CW'(ret_acc) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(ret_acc);
    rd_ptr_d   = rd_ptr_q + PW'(pop);

    unique case ({call_acc, ret_acc})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (cfg_acc && (bus.cfg_count != 16'd0)) begin
          state_d    = ISSUE;
          base_d     = bus.cfg_base;
          count_d    = bus.cfg_count;
          issued_d   = '0;
          returned_d = '0;
          outst_d    = '0;
        end
      end
      ISSUE: begin
        if (call_acc && (issued_q == count_q - 16'd1)) state_d = DRAIN;
      end
      DRAIN: begin
        // Leaving on the pop of the last-tagged entry makes cfg_ready rise right after it.
        if ((returned_d == count_q) && (occ_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from next-state values.
    credit_used = {1'b0, outst_d} + {1'b0, occ_d};
    fir_start_d = (state_d == ISSUE) && (issued_d < count_d) &&
                  (credit_used < (CW+1)'(DEPTH));
    fir_stall_d = (occ_d == CW'(DEPTH));
    res_valid_d = (occ_d != '0);
    cfg_ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      returned_q  <= '0;
      outst_q     <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fir_start_q <= 1'b0;
      fir_stall_q <= 1'b0;
      res_valid_q <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      returned_q  <= returned_d;
      outst_q     <= outst_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fir_start_q <= fir_start_d;
      fir_stall_q <= fir_stall_d;
      res_valid_q <= res_valid_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  // NOTE: the result storage has no reset; entries are only observed once the
  // reset-cleared pointers and occupancy mark them as written.
  always_ff @(posedge clock) begin
    if (ret_acc) mem_q[wr_ptr_q] <= push_entry;
  end

  assign bus.cfg_ready  = cfg_ready_q;
  assign bus.run_active = !cfg_ready_q;
  assign bus.fir_start  = fir_start_q;
  assign bus.fir_d_i    = base_q;
  assign bus.fir_idx    = {48'd0, issued_q};
  assign bus.fir_stall  = fir_stall_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_valid_q ? mem_q[rd_ptr_q].data : 32'd0;
  assign bus.res_last   = res_valid_q && mem_q[rd_ptr_q].last;

endmodule
